// File: rtl/frontend_command_definition_pkg.sv
// Shared definitions for the frontend command path: opcodes, command word layout,
// dispatcher states and default widths.
package frontend_command_definition_pkg;

    localparam int unsigned DEF_NUM_BANKS       = 8;
    localparam int unsigned DEF_BANK_BITS       = $clog2(DEF_NUM_BANKS);
    localparam int unsigned DEF_ROW_BITS        = 14;
    localparam int unsigned DEF_COL_BITS        = 10;
    localparam int unsigned DEF_ID_BITS         = 4;
    localparam int unsigned DEF_MAX_OUTSTANDING = 8;

    typedef enum logic [1:0] {
        OP_NOP   = 2'd0,
        OP_READ  = 2'd1,
        OP_WRITE = 2'd2,
        OP_RSVD  = 2'd3
    } cmd_op_e;

    // Packed MSB-first, so op lands in the LSBs of the word.
    typedef struct packed {
        logic [DEF_ID_BITS-1:0]   id;
        logic [DEF_COL_BITS-1:0]  col;
        logic [DEF_ROW_BITS-1:0]  row;
        logic [DEF_BANK_BITS-1:0] bank;
        cmd_op_e                  op;
    } frontend_cmd_t;

    typedef enum logic [1:0] {
        S_IDLE        = 2'd0,
        S_ISSUE       = 2'd1,
        S_CREDIT_WAIT = 2'd2
    } disp_state_e;

    function automatic logic op_is_issuable(input cmd_op_e op);
        return (op == OP_READ) || (op == OP_WRITE);
    endfunction

endpackage

// File: rtl/frontend_cmd_dispatcher_credit_ctr.sv
// Outstanding-read credit counter: up on read issue, down on read completion,
// sticky underflow flag when a completion arrives with nothing outstanding.
module dispatch_credit_ctr
    import frontend_command_definition_pkg::*;
#(
    parameter  int unsigned MAX_OUTSTANDING = DEF_MAX_OUTSTANDING,
    localparam int unsigned W               = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_inc,
    input  logic         i_dec,
    output logic [W-1:0] o_cnt,
    output logic         o_underflow
);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_cnt       <= '0;
            o_underflow <= 1'b0;
        end else begin
            if (i_dec && (o_cnt == '0))
                o_underflow <= 1'b1;
            if (i_inc && !i_dec)
                o_cnt <= o_cnt + W'(1);
            else if (i_dec && !i_inc && (o_cnt != '0))
                o_cnt <= o_cnt - W'(1);
        end
    end

endmodule

// File: rtl/frontend_cmd_dispatcher.sv
// Routes show-ahead FIFO commands to one-hot bank handshakes, meters reads with credits.
// Optional stall counter output enabled by CMD_DISPATCH_STALL_CNT_EN.
module frontend_cmd_dispatcher
    import frontend_command_definition_pkg::*;
#(
    parameter  int unsigned NUM_BANKS       = DEF_NUM_BANKS,
    parameter  int unsigned ROW_BITS        = DEF_ROW_BITS,
    parameter  int unsigned COL_BITS        = DEF_COL_BITS,
    parameter  int unsigned ID_BITS         = DEF_ID_BITS,
    parameter  int unsigned MAX_OUTSTANDING = DEF_MAX_OUTSTANDING,
    localparam int unsigned BANK_BITS       = $clog2(NUM_BANKS),
    localparam int unsigned CMD_W           = 2 + BANK_BITS + ROW_BITS + COL_BITS + ID_BITS,
    localparam int unsigned CREDIT_W        = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic [CMD_W-1:0]     i_fifo_data,
    input  logic                 i_fifo_empty,
    output logic                 o_fifo_rd_en,
    output logic [NUM_BANKS-1:0] o_bank_valid,
    input  logic [NUM_BANKS-1:0] i_bank_ready,
    output logic [CMD_W-1:0]     o_cmd,
    input  logic                 i_rd_done,
    output logic [CREDIT_W-1:0]  o_credit_cnt,
    output logic [7:0]           o_drop_cnt,
`ifdef CMD_DISPATCH_STALL_CNT_EN
    output logic [15:0]          o_stall_cnt,
`endif
    output logic                 o_err
);

    disp_state_e          state;
    cmd_op_e              head_op;
    logic [BANK_BITS-1:0] head_bank;
    logic                 credit_avail;
    logic                 head_ok;
    logic                 read_blocked;
    logic                 fire;
    logic                 slot_free;
    logic                 pop_issue;
    logic                 pop_drop;
    logic                 credit_inc;

    assign head_op      = cmd_op_e'(i_fifo_data[1:0]);
    assign head_bank    = i_fifo_data[2 +: BANK_BITS];
    // Registered count only: a same-cycle completion does not open a slot.
    assign credit_avail = (o_credit_cnt < CREDIT_W'(MAX_OUTSTANDING));
    assign head_ok      = !i_fifo_empty && ((head_op != OP_READ) || credit_avail);
    assign read_blocked = !i_fifo_empty && (head_op == OP_READ) && !credit_avail;
    assign fire         = |(o_bank_valid & i_bank_ready);
    assign slot_free    = (state == S_IDLE) || fire;
    assign o_fifo_rd_en = slot_free && head_ok;
    assign pop_issue    = o_fifo_rd_en && op_is_issuable(head_op);
    assign pop_drop     = o_fifo_rd_en && !op_is_issuable(head_op);
    assign credit_inc   = o_fifo_rd_en && (head_op == OP_READ);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state        <= S_IDLE;
            o_bank_valid <= '0;
            o_cmd        <= '0;
            o_drop_cnt   <= '0;
        end else begin
            if (pop_drop && (o_drop_cnt != 8'hFF))
                o_drop_cnt <= o_drop_cnt + 8'd1;

            case (state)
                S_IDLE, S_ISSUE: begin
                    if (pop_issue) begin
                        state        <= S_ISSUE;
                        o_bank_valid <= NUM_BANKS'(1) << head_bank;
                        o_cmd        <= i_fifo_data;
                    end else if (slot_free) begin
                        o_bank_valid <= '0;
                        state        <= read_blocked ? S_CREDIT_WAIT : S_IDLE;
                    end
                end
                S_CREDIT_WAIT: begin
                    if (i_rd_done || i_fifo_empty)
                        state <= S_IDLE;
                end
                default: begin
                    state        <= S_IDLE;
                    o_bank_valid <= '0;
                end
            endcase
        end
    end

    dispatch_credit_ctr #(
        .MAX_OUTSTANDING(MAX_OUTSTANDING)
    ) u_credit_ctr (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_inc       (credit_inc),
        .i_dec       (i_rd_done),
        .o_cnt       (o_credit_cnt),
        .o_underflow (o_err)
    );

`ifdef CMD_DISPATCH_STALL_CNT_EN
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            o_stall_cnt <= '0;
        else if ((|o_bank_valid) && !fire && (o_stall_cnt != 16'hFFFF))
            o_stall_cnt <= o_stall_cnt + 16'd1;
    end
`endif

endmodule

// File: tb/tb_frontend_cmd_dispatcher.sv
// Directed bench for frontend_cmd_dispatcher with a small show-ahead FIFO model.
module tb_frontend_cmd_dispatcher;
    import frontend_command_definition_pkg::*;

    localparam int unsigned NB    = 8;
    localparam int unsigned MO    = 2;
    localparam int unsigned CMD_W = 2 + 3 + 14 + 10 + 4;

    logic              clk = 1'b0;
    logic              rst;
    logic [CMD_W-1:0]  fifo_data;
    logic              fifo_empty;
    logic              rd_en;
    logic [NB-1:0]     bank_valid;
    logic [NB-1:0]     bank_ready;
    logic [CMD_W-1:0]  cmd;
    logic              rd_done;
    logic [1:0]        credit;
    logic [7:0]        drop;
    logic              err;
`ifdef CMD_DISPATCH_STALL_CNT_EN
    logic [15:0]       stall;
`endif

    int unsigned total = 0;
    int unsigned bad   = 0;

    logic [CMD_W-1:0] mem [0:31];
    int unsigned wr_ptr = 0;
    int unsigned rd_ptr = 0;

    always #5 clk = ~clk;

    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_data  = mem[rd_ptr[4:0]];

    always @(posedge clk) if (rd_en) rd_ptr <= rd_ptr + 1;

    frontend_cmd_dispatcher #(
        .NUM_BANKS(NB),
        .ROW_BITS(14),
        .COL_BITS(10),
        .ID_BITS(4),
        .MAX_OUTSTANDING(MO)
    ) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_fifo_data  (fifo_data),
        .i_fifo_empty (fifo_empty),
        .o_fifo_rd_en (rd_en),
        .o_bank_valid (bank_valid),
        .i_bank_ready (bank_ready),
        .o_cmd        (cmd),
        .i_rd_done    (rd_done),
        .o_credit_cnt (credit),
        .o_drop_cnt   (drop),
`ifdef CMD_DISPATCH_STALL_CNT_EN
        .o_stall_cnt  (stall),
`endif
        .o_err        (err)
    );

    function automatic logic [CMD_W-1:0] mk(input cmd_op_e op, input int unsigned bank,
                                             input int unsigned row, input int unsigned id);
        frontend_cmd_t c;
        c.op   = op;
        c.bank = 3'(bank);
        c.row  = 14'(row);
        c.col  = 10'(row + 7);
        c.id   = 4'(id);
        return c;
    endfunction

    task automatic push(input logic [CMD_W-1:0] w);
        mem[wr_ptr[4:0]] = w;
        wr_ptr = wr_ptr + 1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    logic [CMD_W-1:0] w [0:3];
    int unsigned p;

    initial begin
        #50000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst        = 1'b1;
        bank_ready = '1;
        rd_done    = 1'b0;
        tick();
        tick();
        chk("rst_valid",  64'(bank_valid), 64'h0);
        chk("rst_cmd",    64'(cmd),        64'h0);
        chk("rst_credit", 64'(credit),     64'h0);
        chk("rst_drop",   64'(drop),       64'h0);
        chk("rst_err",    64'(err),        64'h0);
        rst = 1'b0;
        tick();

        // streaming: banks 0..3 back to back
        for (int i = 0; i < 4; i++) begin
            w[i] = mk(OP_WRITE, i, 16 + i, i);
            push(w[i]);
        end
        p = rd_ptr;
        #1;
        chk("str_rd_en0", 64'(rd_en), 64'h1);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("str_valid", 64'(bank_valid), 64'(1 << i));
            chk("str_cmd",   64'(cmd),        64'(w[i]));
            chk("str_pops",  64'(rd_ptr - p), 64'(i + 1));
        end
        tick();
        chk("str_valid_end", 64'(bank_valid), 64'h0);

        // backpressure on bank 5
        bank_ready = 8'hDF;
        w[0] = mk(OP_WRITE, 5, 291, 9);
        w[1] = mk(OP_WRITE, 6, 292, 10);
        push(w[0]);
        push(w[1]);
        tick();
        for (int i = 0; i < 3; i++) begin
            chk("bp_valid", 64'(bank_valid), 64'h20);
            chk("bp_cmd",   64'(cmd),        64'(w[0]));
            chk("bp_rd_en", 64'(rd_en),      64'h0);
            tick();
        end
        bank_ready = '1;
        #1;
        chk("bp_valid4", 64'(bank_valid), 64'h20);
        chk("bp_cmd4",   64'(cmd),        64'(w[0]));
        chk("bp_rd_en4", 64'(rd_en),      64'h1);
        tick();
        chk("bp_next_valid", 64'(bank_valid), 64'h40);
        chk("bp_next_cmd",   64'(cmd),        64'(w[1]));
        tick();
        chk("bp_idle", 64'(bank_valid), 64'h0);

        // credits with MAX_OUTSTANDING=2
        for (int i = 0; i < 3; i++) begin
            w[i] = mk(OP_READ, 1, 100 + i, 3 + i);
            push(w[i]);
        end
        #1;
        chk("cr_rd_en0", 64'(rd_en), 64'h1);
        tick();
        chk("cr_cmd0",   64'(cmd),    64'(w[0]));
        chk("cr_cnt1",   64'(credit), 64'h1);
        chk("cr_rd_en1", 64'(rd_en),  64'h1);
        tick();
        chk("cr_cmd1",   64'(cmd),    64'(w[1]));
        chk("cr_cnt2",   64'(credit), 64'h2);
        chk("cr_rd_en2", 64'(rd_en),  64'h0);
        tick();
        chk("cr_valid_w", 64'(bank_valid), 64'h0);
        chk("cr_state_w", 64'(dut.state),  64'(S_CREDIT_WAIT));
        tick();
        chk("cr_state_w2", 64'(dut.state), 64'(S_CREDIT_WAIT));
        rd_done = 1'b1;
        #1;
        chk("cr_no_same_cycle", 64'(rd_en), 64'h0);
        tick();
        rd_done = 1'b0;
        #1;
        chk("cr_cnt_ret",  64'(credit),    64'h1);
        chk("cr_state_id", 64'(dut.state), 64'(S_IDLE));
        chk("cr_rd_en3",   64'(rd_en),     64'h1);
        tick();
        chk("cr_cmd2",   64'(cmd),        64'(w[2]));
        chk("cr_valid2", 64'(bank_valid), 64'h02);
        chk("cr_cnt2b",  64'(credit),     64'h2);
        tick();
        rd_done = 1'b1;
        tick();
        tick();
        rd_done = 1'b0;
        #1;
        chk("cr_cnt_zero", 64'(credit), 64'h0);
        chk("cr_err_zero", 64'(err),    64'h0);

        // drop NOP and RSVD, then write bank 7
        p = rd_ptr;
        push(mk(OP_NOP, 3, 1, 1));
        push(mk(OP_RSVD, 4, 2, 2));
        w[0] = mk(OP_WRITE, 7, 3, 3);
        push(w[0]);
        tick();
        chk("drop_valid1", 64'(bank_valid), 64'h0);
        chk("drop_cnt1",   64'(drop),       64'h1);
        tick();
        chk("drop_valid2", 64'(bank_valid), 64'h0);
        chk("drop_cnt2",   64'(drop),       64'h2);
        tick();
        chk("drop_valid3", 64'(bank_valid), 64'h80);
        chk("drop_cmd3",   64'(cmd),        64'(w[0]));
        chk("drop_cnt3",   64'(drop),       64'h2);
        tick();
        chk("drop_pops",   64'(rd_ptr - p), 64'h3);

        // underflow, then simultaneous issue and return at count 1
        rd_done = 1'b1;
        tick();
        rd_done = 1'b0;
        #1;
        chk("uf_err",    64'(err),    64'h1);
        chk("uf_cnt",    64'(credit), 64'h0);
        tick();
        chk("uf_sticky", 64'(err),    64'h1);
        push(mk(OP_READ, 1, 50, 5));
        tick();
        chk("uf_cnt1", 64'(credit), 64'h1);
        w[1] = mk(OP_READ, 1, 51, 6);
        push(w[1]);
        rd_done = 1'b1;
        #1;
        chk("uf_rd_en", 64'(rd_en), 64'h1);
        tick();
        rd_done = 1'b0;
        #1;
        chk("uf_net0", 64'(credit), 64'h1);
        chk("uf_cmd",  64'(cmd),    64'(w[1]));
        tick();

        // async reset while holding a command to bank 2
        bank_ready = 8'hFB;
        push(mk(OP_WRITE, 2, 77, 7));
        tick();
        chk("ar_held", 64'(bank_valid), 64'h04);
        rst = 1'b1;
        #1;
        chk("ar_valid",  64'(bank_valid), 64'h0);
        chk("ar_credit", 64'(credit),     64'h0);
        chk("ar_err",    64'(err),        64'h0);
        chk("ar_cmd",    64'(cmd),        64'h0);
        tick();
        rst        = 1'b0;
        bank_ready = '1;
        p = rd_ptr;
        tick();
        tick();
        chk("ar_no_reissue", 64'(bank_valid), 64'h0);
        chk("ar_no_pop",     64'(rd_ptr - p), 64'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/frontend_cmd_dispatcher.md
Name: frontend_cmd_dispatcher

Overview:
- Consumes frontend commands from the show-ahead command FIFO's read side and routes each to one of NUM_BANKS bank controllers over a one-hot valid/ready handshake.
- Meters outstanding reads with a credit counter returned by the read-data path.
- Drops NOP/reserved opcodes.
- Sits directly downstream of the command FIFO, upstream of the per-bank controllers.

Parameters:
- NUM_BANKS, 8, number of bank controllers; power of two.
- ROW_BITS, 14, row address width.
- COL_BITS, 10, column address width.
- ID_BITS, 4, command tag width.
- MAX_OUTSTANDING, 8, maximum reads in flight (1..255).

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  reset; asynchronous, active-high.
- i_fifo_data  in  CMD_W  FIFO head word; valid whenever i_fifo_empty=0.
- i_fifo_empty  in  1  FIFO empty flag.
- o_fifo_rd_en  out  1  pop strobe; combinational.
- o_bank_valid  out  NUM_BANKS  one-hot command valid.
- i_bank_ready  in  NUM_BANKS  per-bank ready.
- o_cmd  out  CMD_W  held command, broadcast to all banks.
- i_rd_done  in  1  one read completed; returns one credit.
- o_credit_cnt  out  clog2(MAX_OUTSTANDING+1)  reads in flight.
- o_drop_cnt  out  8  dropped-opcode count; saturating.
- o_err  out  1  sticky: credit underflow.

Behaviour:
- Reset values (asynchronous, on i_rst=1): state S_IDLE; o_bank_valid=0; o_cmd=0; o_credit_cnt=0; o_drop_cnt=0; o_err=0. A command held mid-operation is discarded and not re-issued.
- Command word fields, LSB up: op[1:0], bank[clog2(NUM_BANKS)], row, col, id. CMD_W = 2+clog2(NUM_BANKS)+ROW_BITS+COL_BITS+ID_BITS.
- Opcodes: NOP=0, READ=1, WRITE=2, RSVD=3.
- fire = |(o_bank_valid & i_bank_ready).
- slot_free = (state==S_IDLE) | fire.
- head_ok = !i_fifo_empty & (op!=READ | o_credit_cnt<MAX_OUTSTANDING). Use the registered count only; a same-cycle credit return does not unblock.
- o_fifo_rd_en = slot_free & head_ok.
- On pop with op READ/WRITE: o_cmd <= head; o_bank_valid <= 1<<bank on the next edge. Latency from pop to valid is 1 cycle.
- On pop with op NOP/RSVD: the word is consumed; o_drop_cnt increments, saturating at 255; o_bank_valid <= 0.
- Throughput: back-to-back, one command per cycle when ready stays high.
- o_bank_valid and o_cmd stay stable until fire; valid is never withdrawn.
- States:
  - S_IDLE: nothing held. Pop of a valid op -> S_ISSUE. Head is a READ with no credit -> S_CREDIT_WAIT. Otherwise stay.
  - S_ISSUE: holding. fire with a new valid-op pop -> S_ISSUE. fire with no pop -> S_IDLE, or S_CREDIT_WAIT if the head is a READ with no credit. No fire -> stay.
  - S_CREDIT_WAIT: nothing held; o_fifo_rd_en=0. i_rd_done=1 or FIFO empty -> S_IDLE.
- Credits: +1 when a READ is popped; -1 on i_rd_done. Both in the same cycle: net 0.
- i_rd_done with count 0: the count stays 0 and o_err is set.
- o_err clears only on reset.

Optional Feature:
- Macro: CMD_DISPATCH_STALL_CNT_EN.
- Defined: adds output o_stall_cnt[15:0]. It increments each cycle with |o_bank_valid & !fire, saturates at 16'hFFFF, and resets to 0.
- Undefined: the port and the counter are absent; all other behaviour is identical.

Decomposition:
- Shared package frontend_command_definition_pkg holds:
  - op enum (NOP/READ/WRITE/RSVD);
  - packed frontend_cmd_t struct (op, bank, row, col, id);
  - dispatcher state enum;
  - default width constants.
- One sub-module, dispatch_credit_ctr: up/down credit counter with underflow flag. Everything else stays inline.

Test Plan:
- Reset: assert i_rst mid-S_ISSUE with o_bank_valid=8'h04 -> o_bank_valid=0, o_credit_cnt=0, o_err=0 immediately; no re-issue after release.
- Streaming: 4 WRITEs to banks 0,1,2,3 with all ready=1 -> 4 pops on consecutive cycles; o_bank_valid 01,02,04,08 on consecutive cycles, each 1 cycle after its pop.
- Backpressure: WRITE to bank 5 with i_bank_ready[5]=0 for 3 cycles -> o_bank_valid=8'h20 and o_cmd stable for 4 cycles; no pop until the ready cycle.
- Credits (MAX_OUTSTANDING=2): 3 READs, no i_rd_done -> 2 issued, o_credit_cnt=2, state S_CREDIT_WAIT. One i_rd_done -> 3rd read popped 1 cycle later; o_credit_cnt stays 2.
- Drop: NOP, RSVD, then WRITE bank 7 -> o_drop_cnt=2; only o_bank_valid=8'h80 is ever asserted.
- Underflow: i_rd_done pulse at o_credit_cnt=0 -> o_err=1 and stays 1; o_credit_cnt=0. Simultaneous READ pop and i_rd_done at count 1 -> count stays 1.
